// File: rtl/write_info.sv
// rtl/write_info.sv - write-side request tracker: moves queued {pu_id, size} requests
// from the PU output FIFOs into the shared outbound write buffer.
module write_info #(
    parameter int NUM_PU      = 1,
    parameter int DATA_W      = 64,
    parameter int WR_SIZE_W   = 20,
    parameter int INFO_ADDR_W = 5,
    parameter int PU_ID_W     = $clog2(NUM_PU) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [WR_SIZE_W-1:0]     wr_req_size,
    input  logic [PU_ID_W-1:0]       wr_req_pu_id,
    output logic                     write_info_full,
    input  logic [NUM_PU-1:0]        pu_empty,
    output logic [NUM_PU-1:0]        pu_pop,
    input  logic [NUM_PU*DATA_W-1:0] pu_data_in,
    input  logic                     outbuf_full,
    output logic                     outbuf_push,
    output logic [DATA_W-1:0]        outbuf_data,
    output logic                     wr_done,
    output logic                     busy
);

    localparam int INFO_W = PU_ID_W + WR_SIZE_W;
    localparam int DEPTH  = 1 << INFO_ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic [INFO_W-1:0]      r_info_mem [DEPTH];
    logic [INFO_ADDR_W:0]   r_wr_ptr;
    logic [INFO_ADDR_W:0]   r_rd_ptr;
    logic [INFO_W-1:0]      r_info_q;

    logic [1:0]             r_state;
    logic [PU_ID_W-1:0]     r_cur_id;
    logic [WR_SIZE_W-1:0]   r_cur_size;
    logic [WR_SIZE_W-1:0]   r_beat_cnt;

    logic                   r_pop_d1;
    logic                   r_last_d1;
    logic [PU_ID_W-1:0]     r_id_d1;
    logic                   r_done_d2;

    logic                   w_info_empty;
    logic                   w_info_full;
    logic                   w_info_push;
    logic                   w_info_pop;
    logic [PU_ID_W-1:0]     w_info_id;
    logic [WR_SIZE_W-1:0]   w_info_size;
    logic                   w_info_bad;
    logic                   w_load_done;
    logic                   w_sel_empty;
    logic [DATA_W-1:0]      w_sel_data;
    logic                   w_fire;
    logic                   w_last;

    // Info FIFO: extra pointer MSB distinguishes full from empty.
    assign w_info_empty = (r_wr_ptr == r_rd_ptr);
    assign w_info_full  = (r_wr_ptr[INFO_ADDR_W] != r_rd_ptr[INFO_ADDR_W]) &&
                          (r_wr_ptr[INFO_ADDR_W-1:0] == r_rd_ptr[INFO_ADDR_W-1:0]);
    assign w_info_push  = wr_req && !w_info_full;
    assign w_info_pop   = (r_state == S_IDLE) && !w_info_empty;

    always_ff @(posedge clk) begin
        if (w_info_push) begin
            r_info_mem[r_wr_ptr[INFO_ADDR_W-1:0]] <= {wr_req_pu_id, wr_req_size};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_info_q <= '0;
        end else begin
            if (w_info_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_info_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_info_q <= r_info_mem[r_rd_ptr[INFO_ADDR_W-1:0]];
            end
        end
    end

    assign w_info_id   = r_info_q[INFO_W-1 -: PU_ID_W];
    assign w_info_size = r_info_q[WR_SIZE_W-1:0];
    assign w_info_bad  = (w_info_size == '0) || (int'(w_info_id) >= NUM_PU);
    assign w_load_done = (r_state == S_LOAD) && w_info_bad;

    always_comb begin
        w_sel_empty = 1'b1;
        w_sel_data  = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            if (r_cur_id == PU_ID_W'(k)) begin
                w_sel_empty = pu_empty[k];
            end
            if (r_id_d1 == PU_ID_W'(k)) begin
                w_sel_data = pu_data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_fire = (r_state == S_XFER) && !w_sel_empty && !outbuf_full;
    assign w_last = w_fire && (r_beat_cnt == r_cur_size - WR_SIZE_W'(1));

    always_comb begin
        pu_pop = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            pu_pop[k] = w_fire && (r_cur_id == PU_ID_W'(k));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cur_id   <= '0;
            r_cur_size <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_info_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cur_id   <= w_info_id;
                    r_cur_size <= w_info_size;
                    r_beat_cnt <= '0;
                    r_state    <= w_info_bad ? S_IDLE : S_XFER;
                end
                S_XFER: begin
                    if (w_fire) begin
                        r_beat_cnt <= r_beat_cnt + WR_SIZE_W'(1);
                    end
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-stage return path: PU word arrives one cycle after pop, then is registered out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pop_d1    <= 1'b0;
            r_last_d1   <= 1'b0;
            r_id_d1     <= '0;
            outbuf_push <= 1'b0;
            outbuf_data <= '0;
            r_done_d2   <= 1'b0;
        end else begin
            r_pop_d1    <= w_fire;
            r_last_d1   <= w_last;
            r_id_d1     <= r_cur_id;
            outbuf_push <= r_pop_d1;
            r_done_d2   <= r_last_d1;
            if (r_pop_d1) begin
                outbuf_data <= w_sel_data;
            end
        end
    end

    assign write_info_full = w_info_full;
    assign wr_done         = w_load_done | r_done_d2;
    assign busy            = (r_state != S_IDLE) || !w_info_empty;

endmodule

// File: tb/tb_write_info.sv
// tb/tb_write_info.sv - self-checking bench for write_info with a PU FIFO model and
// an ordered beat scoreboard.
module tb_write_info;

    localparam int NUM_PU      = 2;
    localparam int DATA_W      = 64;
    localparam int WR_SIZE_W   = 20;
    localparam int INFO_ADDR_W = 5;
    localparam int PU_ID_W     = 2;

    logic                     clk;
    logic                     reset;
    logic                     wr_req;
    logic [WR_SIZE_W-1:0]     wr_req_size;
    logic [PU_ID_W-1:0]       wr_req_pu_id;
    logic                     write_info_full;
    logic [NUM_PU-1:0]        pu_empty;
    logic [NUM_PU-1:0]        pu_pop;
    logic [NUM_PU*DATA_W-1:0] pu_data_in;
    logic                     outbuf_full;
    logic                     outbuf_push;
    logic [DATA_W-1:0]        outbuf_data;
    logic                     wr_done;
    logic                     busy;

    write_info #(
        .NUM_PU(NUM_PU), .DATA_W(DATA_W), .WR_SIZE_W(WR_SIZE_W), .INFO_ADDR_W(INFO_ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_req_size(wr_req_size),
        .wr_req_pu_id(wr_req_pu_id), .write_info_full(write_info_full),
        .pu_empty(pu_empty), .pu_pop(pu_pop), .pu_data_in(pu_data_in),
        .outbuf_full(outbuf_full), .outbuf_push(outbuf_push), .outbuf_data(outbuf_data),
        .wr_done(wr_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          last;
        bit          degen;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        mon_e;
    int unsigned  exp_next[NUM_PU];
    int unsigned  pu_next[NUM_PU];
    logic [63:0]  pu_word[NUM_PU];
    logic [NUM_PU-1:0] pu_pops_seen;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_pops   = 0;
    int           exp_beats = 0;
    logic [15:0]  m_p0, m_p1, m_ps, m_dn;

    assign pu_data_in = {pu_word[1], pu_word[0]};

    function automatic logic [63:0] mk_word(input int k, input int unsigned idx);
        return {16'(k), 16'hA5C3, idx};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outcome of one request: its beats in PU order, or a bare completion.
    task automatic add_req(input int id, input int sz);
        beat_t b;
        if (sz == 0 || id >= NUM_PU) begin
            b.data = '0; b.last = 1'b1; b.degen = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int j = 0; j < sz; j++) begin
                b.data  = mk_word(id, exp_next[id]);
                b.last  = (j == sz - 1);
                b.degen = 1'b0;
                exp_next[id]++;
                exp_q.push_back(b);
            end
            exp_beats += sz;
        end
    endtask

    // PU output FIFOs: a popped word becomes visible the following cycle.
    initial begin
        for (int k = 0; k < NUM_PU; k++) begin
            pu_next[k] = 0;
            pu_word[k] = '0;
        end
        forever begin
            @(negedge clk);
            pu_pops_seen = pu_pop;
            @(posedge clk);
            #1;
            for (int k = 0; k < NUM_PU; k++) begin
                if (pu_pops_seen[k]) begin
                    pu_word[k] = mk_word(k, pu_next[k]);
                    pu_next[k]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (pu_pop != '0) begin
                n_pops++;
                chk("pop_legal", {63'b0, $onehot(pu_pop) && ((pu_pop & pu_empty) == '0) && !outbuf_full}, 64'd1);
            end
            if (outbuf_push) begin
                if (exp_q.size() == 0) begin
                    chk("push_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("push_kind", {63'b0, mon_e.degen}, 64'd0);
                    chk("push_data", outbuf_data, mon_e.data);
                    chk("done_align", {63'b0, wr_done}, {63'b0, mon_e.last});
                end
            end else if (wr_done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_degen", {63'b0, mon_e.degen}, 64'd1);
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_cap(input int ida, input int sza, input bit hasb, input int idb,
                           input int szb, input int n,
                           output logic [15:0] p0, output logic [15:0] p1,
                           output logic [15:0] ps, output logic [15:0] dn);
        p0 = '0; p1 = '0; ps = '0; dn = '0;
        @(posedge clk);
        #1;
        wr_req = 1'b1; wr_req_pu_id = PU_ID_W'(ida); wr_req_size = WR_SIZE_W'(sza);
        add_req(ida, sza);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p0[i] = pu_pop[0]; p1[i] = pu_pop[1]; ps[i] = outbuf_push; dn[i] = wr_done;
            @(posedge clk);
            #1;
            if (i == 0 && hasb) begin
                wr_req_pu_id = PU_ID_W'(idb); wr_req_size = WR_SIZE_W'(szb);
                add_req(idb, szb);
            end else begin
                wr_req = 1'b0;
            end
        end
    endtask

    task automatic bp_test();
        int npop = 0, first = -1, last = -1, hold = 0, done_at = -1;
        bit armed = 1'b0;
        @(posedge clk);
        #1;
        wr_req = 1'b1; wr_req_pu_id = 0; wr_req_size = 6;
        add_req(0, 6);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pu_pop[0]) begin
                npop++;
                if (first < 0) first = i;
                last = i;
                if (npop == 2 && !armed) begin
                    armed = 1'b1;
                    hold  = 3;
                end
            end
            if (wr_done) done_at = i;
            @(posedge clk);
            #1;
            wr_req = 1'b0;
            outbuf_full = (hold > 0);
            if (hold > 0) hold--;
        end
        chk("bp_pops", 64'(npop), 64'd6);
        chk("bp_span", 64'(last - first), 64'd8);
        chk("bp_done", 64'(done_at), 64'(last + 2));
    endtask

    task automatic starve_test();
        int np = 0;
        @(posedge clk);
        #1;
        wr_req = 1'b1; wr_req_pu_id = 1; wr_req_size = 5;
        add_req(1, 5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pu_pop != '0) np++;
            @(posedge clk);
            #1;
            wr_req = 1'b0;
            pu_empty = ~pu_empty;
        end
        pu_empty = '0;
        chk("starve_pops", 64'(np), 64'd5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; wr_req = 1'b0; wr_req_size = '0; wr_req_pu_id = '0;
        pu_empty = '1; outbuf_full = 1'b0;
        for (int k = 0; k < NUM_PU; k++) exp_next[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", 64'(pu_pop), 64'd0);
        chk("rst_push", {63'b0, outbuf_push}, 64'd0);
        chk("rst_data", outbuf_data, 64'd0);
        chk("rst_done", {63'b0, wr_done}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_full", {63'b0, write_info_full}, 64'd0);
        reset = 1'b0;
        pu_empty = '0;

        run_cap(0, 4, 1'b0, 0, 0, 12, m_p0, m_p1, m_ps, m_dn);
        chk("single_pop0", 64'(m_p0), 64'h0078);
        chk("single_pop1", 64'(m_p1), 64'h0000);
        chk("single_push", 64'(m_ps), 64'h01E0);
        chk("single_done", 64'(m_dn), 64'h0100);
        wait_idle();

        run_cap(1, 2, 1'b1, 0, 3, 14, m_p0, m_p1, m_ps, m_dn);
        chk("b2b_pop1", 64'(m_p1), 64'h0018);
        chk("b2b_pop0", 64'(m_p0), 64'h0380);
        chk("b2b_push", 64'(m_ps), 64'h0E60);
        chk("b2b_done", 64'(m_dn), 64'h0840);
        wait_idle();

        run_cap(0, 0, 1'b0, 0, 0, 6, m_p0, m_p1, m_ps, m_dn);
        chk("zero_pop", 64'({m_p1, m_p0}), 64'd0);
        chk("zero_push", 64'(m_ps), 64'd0);
        chk("zero_done", 64'(m_dn), 64'h0004);
        wait_idle();

        run_cap(2, 5, 1'b0, 0, 0, 6, m_p0, m_p1, m_ps, m_dn);
        chk("badid_pop", 64'({m_p1, m_p0}), 64'd0);
        chk("badid_push", 64'(m_ps), 64'd0);
        chk("badid_done", 64'(m_dn), 64'h0004);
        wait_idle();

        run_cap(1, 2, 1'b0, 0, 0, 10, m_p0, m_p1, m_ps, m_dn);
        chk("after_degen_pop1", 64'(m_p1), 64'h0018);
        chk("after_degen_pop0", 64'(m_p0), 64'h0000);
        chk("after_degen_push", 64'(m_ps), 64'h0060);
        chk("after_degen_done", 64'(m_dn), 64'h0040);
        wait_idle();

        bp_test();
        wait_idle();
        starve_test();
        wait_idle();

        // Fill the info FIFO behind a stalled transfer, then offer one request too many.
        pu_empty = '1;
        @(posedge clk);
        #1;
        wr_req = 1'b1; wr_req_pu_id = 0; wr_req_size = 1;
        for (int i = 0; i < 33; i++) begin
            add_req(0, 1);
            @(posedge clk);
            #1;
        end
        wr_req = 1'b0;
        @(negedge clk);
        chk("info_full", {63'b0, write_info_full}, 64'd1);
        chk("full_busy", {63'b0, busy}, 64'd1);
        @(posedge clk);
        #1;
        wr_req = 1'b1; wr_req_pu_id = 1; wr_req_size = 3;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        @(negedge clk);
        chk("full_hold", {63'b0, write_info_full}, 64'd1);
        @(posedge clk);
        #1;
        pu_empty = '0;
        wait_idle();

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_PU; k++) pu_empty[k] = ($urandom_range(0, 9) < 3);
            outbuf_full = ($urandom_range(0, 9) < 2);
            if (!write_info_full && $urandom_range(0, 5) == 0) begin
                int id, sz;
                id = $urandom_range(0, NUM_PU - 1);
                sz = $urandom_range(1, 6);
                wr_req = 1'b1; wr_req_pu_id = PU_ID_W'(id); wr_req_size = WR_SIZE_W'(sz);
                add_req(id, sz);
            end else begin
                wr_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        wr_req = 1'b0; pu_empty = '0; outbuf_full = 1'b0;
        wait_idle();
        chk("pop_total", 64'(n_pops), 64'(exp_beats));

        @(posedge clk);
        #1;
        wr_req = 1'b1; wr_req_pu_id = 0; wr_req_size = 8;
        add_req(0, 8);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_pop", 64'(pu_pop), 64'd0);
        chk("midrst_push", {63'b0, outbuf_push}, 64'd0);
        chk("midrst_data", outbuf_data, 64'd0);
        chk("midrst_done", {63'b0, wr_done}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NUM_PU; k++) exp_next[k] = pu_next[k];
        n_pops = 0;
        exp_beats = 0;

        run_cap(0, 2, 1'b0, 0, 0, 10, m_p0, m_p1, m_ps, m_dn);
        chk("postrst_pop0", 64'(m_p0), 64'h0018);
        chk("postrst_push", 64'(m_ps), 64'h0060);
        chk("postrst_done", 64'(m_dn), 64'h0040);
        wait_idle();
        chk("postrst_pop_total", 64'(n_pops), 64'(exp_beats));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
